// File: rtl/tick_timer_pkg.sv
// Shared widths, reset defaults and timer state encoding for the
// traffic-light timing block.
package tl_timing_pkg;

  localparam int CNT_W_DEF       = 27;
  localparam int DIV_DEFAULT_DEF = 100_000;
  localparam int TMR_W_DEF       = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tmr_state_t;

endpackage

// File: rtl/tick_timer_if.sv
// Control/status bundle between the light-sequencing FSM (master) and
// the tick timer (slave).
interface tick_timer_if
  import tl_timing_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TMR_W = TMR_W_DEF
) ();

  logic             en;
  logic             div_load;
  logic [CNT_W-1:0] div_val;
  logic             tick;
  logic             tmr_start;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_busy;
  logic             tmr_done;
  logic [TMR_W-1:0] tmr_remain;

  modport master (
    output en, div_load, div_val, tmr_start, tmr_val,
    input  tick, tmr_busy, tmr_done, tmr_remain
  );

  modport slave (
    input  en, div_load, div_val, tmr_start, tmr_val,
    output tick, tmr_busy, tmr_done, tmr_remain
  );

endinterface

// File: rtl/tick_timer_prescaler.sv
// Reloadable down-counting prescaler: one tick every div_reg enabled clocks.
module tick_prescaler
  import tl_timing_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEFAULT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
  output logic             tick_i,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] div_eff;

  // A zero divisor is treated as 1 so the counter can never wrap.
  assign div_eff = (div_val == '0) ? CNT_W'(1) : div_val;
  assign tick_i  = en & (cnt == '0) & ~div_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_reg <= CNT_W'(DIV_DEFAULT);
      cnt     <= CNT_W'(DIV_DEFAULT - 1);
      tick    <= 1'b0;
    end else begin
      if (div_load) begin
        div_reg <= div_eff;
        cnt     <= div_eff - CNT_W'(1);
      end else if (en) begin
        if (cnt == '0) cnt <= div_reg - CNT_W'(1);
        else           cnt <= cnt - CNT_W'(1);
      end
      tick <= tick_i;
    end
  end

endmodule

// File: rtl/tick_timer.sv
// Prescaled tick source plus a countdown phase timer for light sequencing.
//   state | meaning
//   IDLE  | no phase running, tmr_remain holds
//   RUN   | counting tmr_remain down once per tick
module tick_timer
  import tl_timing_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEFAULT_DEF,
  parameter int TMR_W       = TMR_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  tick_timer_if.slave  bus
);

  logic             tick_i;
  tmr_state_t       state_q, state_d;
  logic [TMR_W-1:0] remain_q, remain_d;
  logic             done_q, done_d;

  tick_prescaler #(
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .div_load (bus.div_load),
    .div_val  (bus.div_val),
    .tick_i   (tick_i),
    .tick     (bus.tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      remain_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      done_q   <= done_d;
    end
  end

  // A start always wins over a coincident tick; that tick is not counted.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    if (bus.tmr_start) begin
      if (bus.tmr_val == '0) begin
        remain_d = '0;
        state_d  = IDLE;
        done_d   = 1'b1;
      end else begin
        remain_d = bus.tmr_val;
        state_d  = RUN;
      end
    end else if (state_q == RUN && tick_i) begin
      if (remain_q == TMR_W'(1)) begin
        remain_d = '0;
        state_d  = IDLE;
        done_d   = 1'b1;
      end else begin
        remain_d = remain_q - TMR_W'(1);
      end
    end
  end

  assign bus.tmr_busy   = (state_q == RUN);
  assign bus.tmr_done   = done_q;
  assign bus.tmr_remain = remain_q;

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: vector table, directed corner
// sequences and randomized traffic against a count-up reference model.
module tb_tick_timer;

  localparam int CW = 8;
  localparam int TW = 4;
  localparam int DD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tick_timer_if #(.CNT_W(CW), .TMR_W(TW)) bus ();

  tick_timer #(.CNT_W(CW), .DIV_DEFAULT(DD), .TMR_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: elapsed enabled clocks in the current period (counts up).
  int m_el, m_div, m_rem;
  bit m_act, m_tick, m_done;

  typedef struct {
    bit en; bit ld; int dv; bit st; int tv;
    bit e_tick; bit e_busy; bit e_done; int e_rem;
  } vec_t;
  vec_t tbl [17];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_el = 0; m_div = DD; m_rem = 0; m_act = 0; m_tick = 0; m_done = 0;
  endtask

  function automatic bit model_tick_i();
    return bus.en && (m_el == m_div - 1) && !bus.div_load;
  endfunction

  task automatic model_step();
    bit ti;
    ti = model_tick_i();
    if (bus.div_load) begin
      m_div = (bus.div_val == 0) ? 1 : int'(bus.div_val);
      m_el  = 0;
    end else if (bus.en) begin
      m_el = (m_el == m_div - 1) ? 0 : m_el + 1;
    end
    m_tick = ti;
    m_done = 0;
    if (bus.tmr_start) begin
      if (bus.tmr_val == 0) begin
        m_rem = 0; m_act = 0; m_done = 1;
      end else begin
        m_rem = int'(bus.tmr_val); m_act = 1;
      end
    end else if (m_act && ti) begin
      m_rem--;
      if (m_rem == 0) begin
        m_act = 0; m_done = 1;
      end
    end
  endtask

  task automatic drive(bit en, bit ld, int dv, bit st, int tv);
    bus.en        = en;
    bus.div_load  = ld;
    bus.div_val   = CW'(dv);
    bus.tmr_start = st;
    bus.tmr_val   = TW'(tv);
  endtask

  task automatic check_model(string tag);
    chk({tag, " tick"},   bus.tick,       m_tick);
    chk({tag, " busy"},   bus.tmr_busy,   m_act);
    chk({tag, " done"},   bus.tmr_done,   m_done);
    chk({tag, " remain"}, bus.tmr_remain, m_rem);
  endtask

  task automatic step_chk(string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit found;

    tbl[0]  = '{1,0,0,0,0, 0,0,0,0};
    tbl[1]  = '{1,0,0,0,0, 0,0,0,0};
    tbl[2]  = '{1,0,0,0,0, 0,0,0,0};
    tbl[3]  = '{1,0,0,0,0, 1,0,0,0};
    tbl[4]  = '{1,0,0,1,3, 0,1,0,3};
    tbl[5]  = '{1,0,0,0,0, 0,1,0,3};
    tbl[6]  = '{1,0,0,0,0, 0,1,0,3};
    tbl[7]  = '{1,0,0,0,0, 1,1,0,2};
    tbl[8]  = '{1,0,0,0,0, 0,1,0,2};
    tbl[9]  = '{1,0,0,0,0, 0,1,0,2};
    tbl[10] = '{1,0,0,0,0, 0,1,0,2};
    tbl[11] = '{1,0,0,0,0, 1,1,0,1};
    tbl[12] = '{1,0,0,0,0, 0,1,0,1};
    tbl[13] = '{1,0,0,0,0, 0,1,0,1};
    tbl[14] = '{1,0,0,0,0, 0,1,0,1};
    tbl[15] = '{1,0,0,0,0, 1,0,1,0};
    tbl[16] = '{1,0,0,0,0, 0,0,0,0};

    drive(0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    @(negedge clk);
    rst = 1'b1;

    // Table: first ticks on edges 4/8/12, then a 3-tick phase.
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].en, tbl[i].ld, tbl[i].dv, tbl[i].st, tbl[i].tv);
      model_step();
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d tick", i),   bus.tick,       tbl[i].e_tick);
      chk($sformatf("vec%0d busy", i),   bus.tmr_busy,   tbl[i].e_busy);
      chk($sformatf("vec%0d done", i),   bus.tmr_done,   tbl[i].e_done);
      chk($sformatf("vec%0d remain", i), bus.tmr_remain, tbl[i].e_rem);
    end

    // Divisor reload mid-period, then clamp of zero to one.
    drive(1, 0, 0, 0, 0);
    step_chk("preload");
    drive(1, 1, 2, 0, 0);
    step_chk("load2");
    chk("load2 no tick", bus.tick, 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 0, 0);
      step_chk("div2");
      if (bus.tick) n++;
    end
    chk("div2 tick count", n, 4);
    drive(1, 1, 0, 0, 0);
    step_chk("load0");
    n = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0);
      step_chk("div1");
      if (bus.tick) n++;
    end
    chk("div1 tick count", n, 5);

    // Enable freeze with three clocks left in the period.
    drive(0, 1, 4, 0, 0);
    step_chk("load4");
    drive(1, 0, 0, 0, 0);
    step_chk("cnt2");
    n = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0);
      step_chk("frozen");
      if (bus.tick) n++;
    end
    chk("frozen tick count", n, 0);
    n = 0;
    found = 0;
    for (int i = 1; i <= 10 && !found; i++) begin
      drive(1, 0, 0, 0, 0);
      step_chk("resume");
      if (bus.tick) begin
        n = i; found = 1;
      end
    end
    chk("resume latency", n, 3);

    // Restart landing on the tick that would have expired the phase.
    drive(1, 0, 0, 1, 1);
    step_chk("start1");
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      drive(1, 0, 0, 0, 0);
      if (model_tick_i()) begin
        drive(1, 0, 0, 1, 5);
        found = 1;
      end
      step_chk("coincide");
    end
    chk("coincide reached", found, 1);
    chk("coincide done", bus.tmr_done, 0);
    chk("coincide remain", bus.tmr_remain, 5);
    chk("coincide busy", bus.tmr_busy, 1);

    drive(1, 0, 0, 1, 0);
    step_chk("start0");
    chk("start0 done", bus.tmr_done, 1);
    chk("start0 busy", bus.tmr_busy, 0);
    drive(1, 0, 0, 0, 0);
    step_chk("start0 after");
    chk("start0 done cleared", bus.tmr_done, 0);

    // Asynchronous reset between edges while a phase is running.
    drive(1, 0, 0, 1, 7);
    step_chk("start7");
    drive(1, 0, 0, 0, 0);
    step_chk("run7");
    chk("run7 busy", bus.tmr_busy, 1);
    #3;
    rst = 1'b0;
    #1;
    chk("async tick", bus.tick, 0);
    chk("async busy", bus.tmr_busy, 0);
    chk("async done", bus.tmr_done, 0);
    chk("async remain", bus.tmr_remain, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 0, 0, 0);
      step_chk("post reset");
      if (bus.tick) n++;
    end
    chk("post reset tick count", n, 3);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
            $urandom_range(0, 5), $urandom_range(0, 14) == 0,
            $urandom_range(0, 6));
      step_chk("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
